// File: rtl/axis_multich_decimator.sv
// axis_multich_decimator
//   AXI-Stream decimator for interleaved multi-channel sample frames.
//   Each input frame is NUM_CH beats (channel 0 first, s_tlast on the last
//   channel). One output frame is emitted per (decim+1) input frames:
//     mode=0 (drop)    : forward the last frame of each window.
//     mode=1 (average) : per-channel boxcar sum, arithmetic right shift by
//                        'shift', saturated to DATA_WIDTH.
//   mode/decim/shift are latched at the first beat of each window.
//
// Optional build macro:
//   AXIS_DECIM_ROUND_EN - average mode rounds half up (adds 2^(shift-1)
//                         before the shift) instead of truncating.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   enable        run; low flushes the window state and discards input
//   mode          0 = drop, 1 = average
//   decim         window length minus one, in frames
//   shift         average-mode right shift (0..ACC_W-1)
//   s_t*          AXI-Stream slave (sample input)
//   m_t*          AXI-Stream master (decimated output, one register stage)
//   frame_err     sticky framing error (s_tlast misplaced)
//   frames_out    wrapping count of completed output frames
module axis_multich_decimator #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH     = 4,
    parameter int CNT_WIDTH  = 16,
    parameter int ACC_GUARD  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  mode,
    input  logic [CNT_WIDTH-1:0]  decim,
    input  logic [4:0]            shift,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic                  s_tlast,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic                  frame_err,
    output logic [31:0]           frames_out
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int ACC_W = DATA_WIDTH + ACC_GUARD;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_GUARD+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_GUARD+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic [CH_W-1:0]         r_ch_idx;
    logic [CNT_WIDTH-1:0]    r_frame_cnt;
    logic [CNT_WIDTH-1:0]    r_decim_l;
    logic                    r_mode_l;
    logic [4:0]              r_shift_l;
    logic signed [ACC_W-1:0] r_acc [NUM_CH];

    logic                    w_xfer;
    logic                    w_start;
    logic                    w_last_ch;
    logic                    w_early_last;
    logic                    w_framing;
    logic                    w_out_beat;
    logic                    w_mode_eff;
    logic [CNT_WIDTH-1:0]    w_decim_eff;
    logic [4:0]              w_shift_eff;
    logic signed [ACC_W-1:0] w_samp_ext;
    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W-1:0] w_rsum;
    logic signed [ACC_W-1:0] w_shifted;
    logic [DATA_WIDTH-1:0]   w_sat;
    logic [DATA_WIDTH-1:0]   w_out_data;

    // Disabled: swallow everything so the upstream source never stalls.
    assign s_tready = !enable || !m_tvalid || m_tready;
    assign w_xfer   = enable && s_tvalid && s_tready;

    // The first beat of a window sees the live config so that decim=0 and
    // the first frame's shift are honoured without a one-frame lag.
    assign w_start     = (r_ch_idx == '0) && (r_frame_cnt == '0);
    assign w_mode_eff  = w_start ? mode  : r_mode_l;
    assign w_decim_eff = w_start ? decim : r_decim_l;
    assign w_shift_eff = w_start ? shift : r_shift_l;

    assign w_last_ch    = (r_ch_idx == LAST_CH);
    assign w_early_last = s_tlast && !w_last_ch;
    assign w_framing    = w_xfer && (s_tlast != w_last_ch);
    assign w_out_beat   = w_xfer && (r_frame_cnt == w_decim_eff);

    assign w_samp_ext = ACC_W'($signed(s_tdata));
    assign w_sum      = r_acc[r_ch_idx] + w_samp_ext;

`ifdef AXIS_DECIM_ROUND_EN
    assign w_rsum = (w_shift_eff != 5'd0)
                  ? w_sum + (ACC_W'(1) << (w_shift_eff - 5'd1))
                  : w_sum;
`else
    assign w_rsum = w_sum;
`endif

    assign w_shifted = w_rsum >>> w_shift_eff;

    always_comb begin
        w_sat = w_shifted[DATA_WIDTH-1:0];
        if (w_shifted > SAT_MAX)
            w_sat = SAT_MAX[DATA_WIDTH-1:0];
        else if (w_shifted < SAT_MIN)
            w_sat = SAT_MIN[DATA_WIDTH-1:0];
    end

    assign w_out_data = w_mode_eff ? w_sat : s_tdata;

    // Window sequencing, config latch, output register and status.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ch_idx    <= '0;
            r_frame_cnt <= '0;
            r_decim_l   <= '0;
            r_mode_l    <= 1'b0;
            r_shift_l   <= '0;
            m_tdata     <= '0;
            m_tvalid    <= 1'b0;
            m_tlast     <= 1'b0;
            frame_err   <= 1'b0;
            frames_out  <= '0;
        end else begin
            if (m_tvalid && m_tready && m_tlast)
                frames_out <= frames_out + 32'd1;

            if (w_out_beat) begin
                m_tvalid <= 1'b1;
                m_tdata  <= w_out_data;
                m_tlast  <= w_last_ch;
            end else if (m_tready) begin
                m_tvalid <= 1'b0;
            end

            if (w_framing)
                frame_err <= 1'b1;

            if (!enable) begin
                r_ch_idx    <= '0;
                r_frame_cnt <= '0;
            end else if (w_xfer) begin
                if (w_start) begin
                    r_mode_l  <= mode;
                    r_decim_l <= decim;
                    r_shift_l <= shift;
                end
                if (w_early_last) begin
                    // Resync on the early tlast; the window position stays.
                    r_ch_idx <= '0;
                end else if (w_last_ch) begin
                    r_ch_idx    <= '0;
                    r_frame_cnt <= (r_frame_cnt == w_decim_eff)
                                 ? '0 : r_frame_cnt + 1'b1;
                end else begin
                    r_ch_idx <= r_ch_idx + 1'b1;
                end
            end
        end
    end

    // Per-channel accumulators. Drop mode keeps them zero so a later
    // average window always starts clean.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (rst || !enable) begin
                r_acc[c] <= '0;
            end else if (w_xfer && (r_ch_idx == CH_W'(c))) begin
                if (w_out_beat || !w_mode_eff)
                    r_acc[c] <= '0;
                else
                    r_acc[c] <= w_sum;
            end
        end
    end

endmodule

// File: doc/axis_multich_decimator.md
Name: axis_multich_decimator

Overview:
- Parametrised AXI-Stream decimator for interleaved multi-channel sample streams, placed between the ADC/sample-generator source and the DMA packer.
- Consumes frames of NUM_CH beats (channel 0 first, s_tlast on the last channel) and emits one frame per (decim+1) input frames.
- Two run-time modes: drop (keep the last frame of each window) and average (per-channel boxcar sum with arithmetic right shift and saturation).
- Full valid/ready backpressure on both sides; sticky framing-error detection with resync.

Parameters:
- DATA_WIDTH, 16, sample width in bits; samples are two's complement.
- NUM_CH, 4, channels per frame (≥1); channel index width CH_W = max(1, clog2(NUM_CH)).
- CNT_WIDTH, 16, width of the decimation factor and frame counter.
- ACC_GUARD, 8, extra accumulator bits; accumulator width ACC_W = DATA_WIDTH + ACC_GUARD.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  run; low = flush and idle
- mode  in  1  0 = drop, 1 = average
- decim  in  CNT_WIDTH  window = decim+1 frames
- shift  in  5  average-mode right shift, 0..ACC_W-1
- s_tdata  in  DATA_WIDTH  input sample
- s_tvalid  in  1  input valid
- s_tready  out  1  input ready
- s_tlast  in  1  last channel of input frame
- m_tdata  out  DATA_WIDTH  output sample
- m_tvalid  out  1  output valid
- m_tready  in  1  output ready
- m_tlast  out  1  last channel of output frame
- frame_err  out  1  sticky framing error
- frames_out  out  32  count of output frames, wraps

Behaviour:
- Reset values: m_tdata=0, m_tvalid=0, m_tlast=0, frame_err=0, frames_out=0. Internal state also resets: ch_idx=0, frame_cnt=0, all accumulators 0, decim_l=0, mode_l=0, shift_l=0.
- s_tready = !m_tvalid || m_tready. This is combinational, single output register stage. An input beat is accepted ("xfer") when s_tvalid && s_tready.
- Latency: an accepted beat that produces output appears on m_* the next cycle. Zero bubbles at full throughput with m_tready held high.
- m_tvalid falls after an output handshake unless a new output beat is loaded in the same cycle.
- Window config latch: mode, decim and shift are sampled into mode_l, decim_l and shift_l on xfer when ch_idx==0 and frame_cnt==0. Changes mid-window take effect at the next window start.
- ch_idx increments on each xfer and wraps to 0 after NUM_CH-1.
- frame_cnt increments on the xfer with ch_idx==NUM_CH-1. It wraps to 0 when it equals decim_l.
- Output beat condition: xfer && frame_cnt==decim_l.
- Drop mode: on an output beat, m_tdata = s_tdata. Non-output beats are consumed with no output.
- Average mode:
  - On every xfer, acc[ch_idx] += sign-extended s_tdata.
  - On an output beat, sum = acc[ch_idx] + s_tdata, and m_tdata = sat(sum >>> shift_l).
  - Saturation clamps to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - acc[ch_idx] is cleared in the same cycle as the output beat.
  - Accumulator wrap beyond ACC_W is undefined. Users must keep decim+1 ≤ 2^ACC_GUARD.
- m_tlast = 1 on the output beat with ch_idx==NUM_CH-1.
- frames_out increments on the m_* handshake with m_tlast=1.
- decim=0: every frame is forwarded. In average mode with shift_l=0 the output equals the input.
- Framing error:
  - Trigger: an xfer where s_tlast != (ch_idx==NUM_CH-1).
  - frame_err is set and stays set until rst.
  - If s_tlast=1 early, ch_idx returns to 0 and frame_cnt is unchanged; a partial output frame may be emitted without m_tlast.
  - If s_tlast=0 on the last channel, counting proceeds normally.
- enable low:
  - s_tready = 1 and all input beats are discarded.
  - ch_idx, frame_cnt and accumulators clear each cycle.
  - A pending m_tvalid beat is held until its handshake; no new output is produced.
  - Raising enable starts a fresh window at channel 0.
- rst mid-frame discards any partial window and any pending output beat immediately.

Optional Feature:
- Macro: AXIS_DECIM_ROUND_EN.
- Defined: average mode adds 2^(shift_l-1) to sum before the shift when shift_l>0 (round half up). Saturation is applied afterwards.
- Undefined: plain truncating arithmetic shift (floor).
- Drop mode is unaffected in both builds.

Test Plan:
- NUM_CH=4, mode=0, decim=2, frames with sample = 16*frame+ch for frames 0..8, m_tready=1. Expect output frames 2, 5, 8, i.e. beats 0x20..0x23, 0x50..0x53, 0x80..0x83. m_tlast on 0x23, 0x53, 0x83; frames_out=3.
- mode=1, decim=3, shift=2, channel 0 samples 10, 11, 12, 13 and channel 1 samples -4, -4, -4, -5:
  - Without the macro: outputs 11 and -5.
  - With AXIS_DECIM_ROUND_EN: outputs 12 and -4.
- mode=1, decim=1, shift=0, channel 0 samples 0x7FFF and 0x7FFF. Expect output 0x7FFF (saturated); next window starts from an accumulator of 0.
- mode=0, decim=0, m_tready toggled 1,0,0,1 per cycle with continuous s_tvalid. Expect no beat lost or duplicated, s_tready low exactly while m_tvalid && !m_tready, and output order identical to input.
- s_tlast asserted on ch_idx=1 with NUM_CH=4. Expect frame_err=1 sticky; next beat treated as channel 0; frame_err stays 1 until rst pulse, then 0.
- decim changed 2→0 mid-window, then enable dropped for 3 cycles mid-frame. Expect the old window to finish with decim=2, the next window to use decim=0, and after enable rises, output to resume at channel 0 with empty accumulators.
